// File: rtl/pdm_tx.sv
// pdm_tx: PCM-to-PDM transmitter.
//
// Signed PCM samples enter a small FIFO over a valid/ready stream. Each sample
// is held for OSR PDM bit periods and fed to a first-order sigma-delta
// modulator. The 1-bit result is driven together with a divided bit clock.
//
// Build option:
//   PDM_TX_TEST_PAT_EN  when defined, the modulator input is fixed at 16'h501A,
//                       the FIFO is bypassed (accepted samples are dropped),
//                       fifo_level stays 0 and underrun never fires.
//
// Ports:
//   clk_board   in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   transmitter enable (sync to clk_board)
//   pcm_valid   in   input sample valid
//   pcm_ready   out  FIFO can accept a sample
//   pcm_data    in   signed PCM sample, PCM_DSIZE bits
//   pdm_clk     out  PDM bit clock; the receiver samples on its rising edge
//   pdm_data    out  PDM bitstream, changes as pdm_clk falls
//   underrun    out  one-cycle pulse: a sample was due and the FIFO was empty
//   fifo_level  out  current FIFO occupancy
module pdm_tx #(
  parameter int PCM_DSIZE  = 16,
  parameter int CLK_DIV    = 20,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_board,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  input  logic [PCM_DSIZE-1:0]          pcm_data,
  output logic                          pdm_clk,
  output logic                          pdm_data,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic                 run;

  logic [DIV_W-1:0]     div, div_nxt;
  logic [BIT_W-1:0]     bit_idx;
  logic [PCM_DSIZE-1:0] acc, cur_sample, mod_sample, u;
  logic [PCM_DSIZE:0]   sum;
  logic                 bit_evt, fetch, underrun_evt;

  logic                 push, pop, full, empty;
  logic [LVL_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [PCM_DSIZE-1:0] mem [FIFO_DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run = (state == RUN);
`ifdef PDM_TX_TEST_PAT_EN
    pcm_ready = run;
`else
    pcm_ready = run && !full;
`endif
  end

  // ---------------------------------------------------------------- timing
  // div is held at 0 in IDLE so the first RUN cycle starts a fresh bit with
  // pdm_clk already high.
  always_comb begin
    div_nxt = '0;
    if (run) div_nxt = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
  end

  // Bit event sits on the last high cycle, so pdm_data moves with the
  // falling edge and is stable for half a period either side of the rise.
  // Gated by en: a disabling cycle must not pop or flag an underrun.
  assign bit_evt = run && en && (div == DIV_W'(HALF - 1));
  assign fetch   = bit_evt && (bit_idx == '0);

  assign empty = (count == '0);
  assign full  = (count == LVL_W'(FIFO_DEPTH));

  // ---------------------------------------------------------------- source select
`ifdef PDM_TX_TEST_PAT_EN
  localparam logic [PCM_DSIZE-1:0] TEST_PAT = PCM_DSIZE'(16'h501A);
  logic unused_in;
  assign unused_in    = &{1'b0, pcm_valid, empty};
  assign push         = 1'b0;
  assign pop          = 1'b0;
  assign underrun_evt = 1'b0;
  assign mod_sample   = TEST_PAT;
`else
  assign push         = pcm_valid && pcm_ready;
  assign pop          = fetch && !empty;
  assign underrun_evt = fetch && empty;
  // A freshly fetched sample drives the very bit it was fetched on.
  always_comb begin
    mod_sample = cur_sample;
    if (fetch) mod_sample = empty ? '0 : mem[rd_ptr];
  end
`endif

  // ---------------------------------------------------------------- modulator
  // Offset binary makes the carry out of the accumulator the PDM bit; the
  // ones density is exactly u / 2^PCM_DSIZE with no clipping case.
  assign u   = {~mod_sample[PCM_DSIZE-1], mod_sample[PCM_DSIZE-2:0]};
  assign sum = {1'b0, acc} + {1'b0, u};

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      cur_sample <= '0;
      pdm_clk    <= 1'b0;
      pdm_data   <= 1'b0;
      underrun   <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (!en) begin
      // Leaving (or staying in) IDLE: discard everything, no drain.
      div        <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      cur_sample <= '0;
      pdm_clk    <= 1'b0;
      pdm_data   <= 1'b0;
      underrun   <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      div      <= div_nxt;
      pdm_clk  <= (div_nxt < DIV_W'(HALF));
      underrun <= underrun_evt;
      if (bit_evt) begin
        bit_idx    <= bit_idx + 1'b1;
        cur_sample <= mod_sample;
        acc        <= sum[PCM_DSIZE-1:0];
        pdm_data   <= sum[PCM_DSIZE];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_board) begin
    if (push) mem[wr_ptr] <= pcm_data;
  end

  assign fifo_level = count;

endmodule

// File: tb/tb_pdm_tx.sv
`timescale 1ns/1ps
module tb_pdm_tx;
  localparam int W = 16;

  logic         clk_board = 1'b0;
  logic         rst_n, en, pcm_valid;
  logic         pcm_ready;
  logic [W-1:0] pcm_data, data_r;
  logic         pdm_clk, pdm_data, underrun;
  logic [2:0]   fifo_level;

  int checks = 0, errors = 0;
  int acc_cnt = 0, cyc = 0, seq_base = 0;
  logic seq_mode;
  bit   bits[$];
  int   utimes[$];
  logic prev_clk = 1'b0;
  logic [W-1:0] pat  [3] = '{16'h0000, 16'h4000, 16'h8000};
  int           wexp [3] = '{32, 48, 0};

  always #5 clk_board = ~clk_board;

  // In sequence mode each accepted sample is the next entry of pat[].
  assign pcm_data = seq_mode ? pat[(acc_cnt - seq_base) % 3] : data_r;

  pdm_tx dut (
    .clk_board (clk_board),
    .rst_n     (rst_n),
    .en        (en),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pcm_data  (pcm_data),
    .pdm_clk   (pdm_clk),
    .pdm_data  (pdm_data),
    .underrun  (underrun),
    .fifo_level(fifo_level)
  );

  always @(posedge clk_board) begin
    cyc <= cyc + 1;
    if (pcm_valid === 1'b1 && pcm_ready === 1'b1 && rst_n === 1'b1) acc_cnt <= acc_cnt + 1;
  end

  // One PDM bit per pdm_clk fall; data has just been updated on that edge.
  always @(negedge clk_board) begin
    if (prev_clk === 1'b1 && pdm_clk === 1'b0 && rst_n === 1'b1) bits.push_back(pdm_data);
    prev_clk = pdm_clk;
    if (underrun === 1'b1) utimes.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n, input string tag);
    int t = 0;
    while (bits.size() < n && t < 40000) begin @(negedge clk_board); t++; end
    chk(tag, 32'(bits.size() >= n), 1);
  endtask

  task automatic wait_clk(input logic v, input string tag);
    int t = 0;
    while (pdm_clk !== v && t < 100) begin @(negedge clk_board); t++; end
    chk(tag, 32'(pdm_clk), 32'(v));
  endtask

  function automatic int ones(input int lo, input int n);
    int s = 0;
    for (int i = lo; i < lo + n; i++) if (i < bits.size()) s += int'(bits[i]);
    return s;
  endfunction

  // First four bits of a window, earliest bit in the MSB.
  function automatic logic [3:0] nib(input int lo);
    return {bits[lo], bits[lo+1], bits[lo+2], bits[lo+3]};
  endfunction

  initial begin
    int base, u0, t, hi, per;
    rst_n = 1'b0; en = 1'b0; pcm_valid = 1'b0; data_r = '0; seq_mode = 1'b0;
    repeat (3) @(negedge clk_board);
    chk("rst_ready",    32'(pcm_ready),  0);
    chk("rst_pdm_clk",  32'(pdm_clk),    0);
    chk("rst_pdm_data", 32'(pdm_data),   0);
    chk("rst_underrun", 32'(underrun),   0);
    chk("rst_level",    32'(fifo_level), 0);
    rst_n = 1'b1;
    @(negedge clk_board);
    chk("idle_ready", 32'(pcm_ready), 0);

`ifdef PDM_TX_TEST_PAT_EN
    en = 1'b1; pcm_valid = 1'b1; data_r = 16'h1234;
    @(negedge clk_board);
    chk("tp_ready", 32'(pcm_ready), 1);
    wait_bits(256, "tp_bits");
    // floor(256 * 0xD01A / 65536) = 208
    chk("tp_ones256", ones(0, 256), 208);
    chk("tp_level",   32'(fifo_level), 0);
    chk("tp_no_underrun", utimes.size(), 0);
    chk("tp_ready_run", 32'(pcm_ready), 1);
`else
    // ---- 1/2: three samples queued back to back
    en = 1'b1; pcm_valid = 1'b1; data_r = 16'h0000;
    @(negedge clk_board);
    chk("run_ready",  32'(pcm_ready), 1);
    chk("run_clk_hi", 32'(pdm_clk),   1);
    @(negedge clk_board);
    chk("lvl1", 32'(fifo_level), 1);
    data_r = 16'h4000;
    @(negedge clk_board);
    data_r = 16'h8000;
    @(negedge clk_board);
    pcm_valid = 1'b0;
    chk("lvl3", 32'(fifo_level), 3);

    t = 0; while (pdm_clk !== 1'b0 && t < 100) begin @(negedge clk_board); t++; end
    t = 0; while (pdm_clk !== 1'b1 && t < 100) begin @(negedge clk_board); t++; end
    hi = 0; while (pdm_clk === 1'b1 && hi < 100) begin @(negedge clk_board); hi++; end
    per = hi; while (pdm_clk === 1'b0 && per < 200) begin @(negedge clk_board); per++; end
    chk("clk_high",   hi,  10);
    chk("clk_period", per, 20);

    wait_bits(256, "t1_bits");
    chk("s0000_head", nib(0),   4'b0101);
    chk("s0000_ones", ones(0, 64),   32);
    chk("s4000_head", nib(64),  4'b0111);
    chk("s4000_ones", ones(64, 64),  48);
    chk("s8000_ones", ones(128, 64), 0);
    chk("mid_head",   nib(192), 4'b0101);
    chk("mid_ones",   ones(192, 64), 32);
    chk("underrun_1", utimes.size(), 1);
    chk("lvl0_drained", 32'(fifo_level), 0);

    // ---- 3: repeated underrun spacing
    t = 0; while (utimes.size() < 3 && t < 5000) begin @(negedge clk_board); t++; end
    chk("underrun_3", 32'(utimes.size() >= 3), 1);
    chk("underrun_gap1", utimes[1] - utimes[0], 1280);
    chk("underrun_gap2", utimes[2] - utimes[1], 1280);
    chk("mid_ones2", ones(256, 64), 32);

    // ---- 4: continuous valid, tagged by pattern per window
    wait_bits(5*64 + 2, "t4_start");
    seq_base = acc_cnt; seq_mode = 1'b1; pcm_valid = 1'b1;
    repeat (8) @(negedge clk_board);
    chk("full_level", 32'(fifo_level), 4);
    chk("full_ready", 32'(pcm_ready),  0);
    chk("acc_fill",   acc_cnt - seq_base, 4);
    wait_bits(6*64 + 2, "t4_w6");
    chk("acc_w6", acc_cnt - seq_base, 5);
    wait_bits(9*64 + 2, "t4_w9");
    chk("acc_w9", acc_cnt - seq_base, 8);
    wait_bits(12*64 + 2, "t4_w12");
    pcm_valid = 1'b0;
    chk("acc_w12", acc_cnt - seq_base, 11);
    for (int j = 0; j < 6; j++) chk($sformatf("seq_win%0d", j), ones((6+j)*64, 64), wexp[j%3]);

    // ---- 5: disable mid-sample with 3 queued
    wait_bits(13*64 + 31, "t5_bit30");
    seq_mode = 1'b0;
    wait_clk(1'b1, "t5_clk_hi");
    chk("t5_bit30_val", 32'(pdm_data),   1);
    chk("t5_level3",    32'(fifo_level), 3);
    en = 1'b0;
    @(negedge clk_board);
    chk("dis_pdm_clk",  32'(pdm_clk),    0);
    chk("dis_pdm_data", 32'(pdm_data),   0);
    chk("dis_level",    32'(fifo_level), 0);
    chk("dis_ready",    32'(pcm_ready),  0);
    @(negedge clk_board);
    base = bits.size(); u0 = utimes.size();
    en = 1'b1; pcm_valid = 1'b1; data_r = 16'h4000;
    @(negedge clk_board);
    @(negedge clk_board);
    data_r = 16'h0000;
    @(negedge clk_board);
    pcm_valid = 1'b0;
    wait_bits(base + 4, "t5_reen");
    chk("reen_head",   nib(base), 4'b0111);
    chk("reen_level",  32'(fifo_level), 1);
    chk("reen_no_urn", utimes.size(), u0);

    // async reset with no intervening clock edge
    wait_clk(1'b1, "t5_clk_hi2");
    chk("pre_rst_data", 32'(pdm_data), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pdm_clk",  32'(pdm_clk),    0);
    chk("arst_pdm_data", 32'(pdm_data),   0);
    chk("arst_ready",    32'(pcm_ready),  0);
    chk("arst_level",    32'(fifo_level), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
